// File: rtl/prog_mem_arbiter_if.sv
// Bus bundle between the fetch port, the loader port and the program memory macro.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface prog_mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_ack;
    logic [DW-1:0] f_rdata;

    logic          l_req;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_gnt;
    logic          l_ack;
    logic [DW-1:0] l_rdata;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    logic          cpu_stall;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
        output f_gnt, f_ack, f_rdata, l_gnt, l_ack, l_rdata,
               m_en, m_we, m_addr, m_wdata, cpu_stall
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
        input  f_gnt, f_ack, f_rdata, l_gnt, l_ack, l_rdata,
               m_en, m_we, m_addr, m_wdata, cpu_stall
    );
endinterface

// File: rtl/prog_mem_arbiter.sv
// Round-robin arbiter serialising CPU fetch and loader accesses onto one program memory port.
// Define ARB_STATS_EN to enable the saturating fetch/load/conflict statistics counters.
module prog_mem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1,
    parameter int STAT_W  = 16
) (
    input  logic               clk,
    input  logic               CLB,
    prog_mem_arbiter_if.slave  bus,
    input  logic               stat_clr,
    output logic [STAT_W-1:0]  stat_fetch,
    output logic [STAT_W-1:0]  stat_load,
    output logic [STAT_W-1:0]  stat_conflict
);

    typedef enum logic [1:0] {IDLE, ACC, WAIT, DONE} state_t;

    typedef struct packed {
        logic          ld;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    state_t        state, state_nxt;
    req_t          lat;
    logic [2:0]    cnt;
    logic          last_ld;
    logic          win_ld;
    logic [DW-1:0] f_rdata_q;
    logic [DW-1:0] l_rdata_q;

    // last_ld resets high so the first conflict goes to fetch
    assign win_ld = bus.l_req & (~bus.f_req | ~last_ld);

    always_ff @(posedge clk) begin
        if (CLB) begin
            state     <= IDLE;
            lat       <= '0;
            cnt       <= '0;
            last_ld   <= 1'b1;
            f_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (bus.f_req || bus.l_req) begin
                    lat.ld    <= win_ld;
                    lat.we    <= win_ld & bus.l_we;
                    lat.addr  <= win_ld ? bus.l_addr : bus.f_addr;
                    lat.wdata <= win_ld ? bus.l_wdata : '0;
                    last_ld   <= win_ld;
                end
                ACC:  cnt <= 3'(MEM_LAT);
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1 && !lat.we) begin
                        if (lat.ld) l_rdata_q <= bus.m_rdata;
                        else        f_rdata_q <= bus.m_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.f_gnt   = 1'b0;
        bus.l_gnt   = 1'b0;
        bus.f_ack   = 1'b0;
        bus.l_ack   = 1'b0;
        bus.m_en    = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        case (state)
            IDLE: if (bus.f_req || bus.l_req) state_nxt = ACC;
            ACC: begin
                bus.m_en    = 1'b1;
                bus.m_we    = lat.we;
                bus.m_addr  = lat.addr;
                bus.m_wdata = lat.wdata;
                bus.f_gnt   = ~lat.ld;
                bus.l_gnt   = lat.ld;
                state_nxt   = WAIT;
            end
            WAIT: begin
                bus.f_gnt = ~lat.ld;
                bus.l_gnt = lat.ld;
                if (cnt == 3'd1) state_nxt = DONE;
            end
            DONE: begin
                bus.f_gnt = ~lat.ld;
                bus.l_gnt = lat.ld;
                bus.f_ack = ~lat.ld;
                bus.l_ack = lat.ld;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.f_rdata   = f_rdata_q;
    assign bus.l_rdata   = l_rdata_q;
    assign bus.cpu_stall = bus.f_req & ~bus.f_ack;

`ifdef ARB_STATS_EN
    // clear wins over a coincident increment
    always_ff @(posedge clk) begin
        if (CLB || stat_clr) begin
            stat_fetch    <= '0;
            stat_load     <= '0;
            stat_conflict <= '0;
        end else begin
            if (bus.f_ack && stat_fetch != '1) stat_fetch <= stat_fetch + 1'b1;
            if (bus.l_ack && stat_load  != '1) stat_load  <= stat_load + 1'b1;
            if (state == IDLE && bus.f_req && bus.l_req && stat_conflict != '1)
                stat_conflict <= stat_conflict + 1'b1;
        end
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_fetch      = '0;
    assign stat_load       = '0;
    assign stat_conflict   = '0;
`endif

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter: one MEM_LAT=1 instance and one MEM_LAT=4/STAT_W=2 instance.
// Memory models return addr^A6 unless written; reads appear exactly MEM_LAT cycles after m_en.
module tb_prog_mem_arbiter;

`ifdef ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic clr_a, clr_b;
    logic [15:0] sf_a, sl_a, sc_a;
    logic [1:0]  sf_b, sl_b, sc_b;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prog_mem_arbiter_if #(.AW(8), .DW(8)) bus_a ();
    prog_mem_arbiter_if #(.AW(8), .DW(8)) bus_b ();

    prog_mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(1), .STAT_W(16)) dut_a (
        .clk(clk), .CLB(rst), .bus(bus_a), .stat_clr(clr_a),
        .stat_fetch(sf_a), .stat_load(sl_a), .stat_conflict(sc_a)
    );

    prog_mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(4), .STAT_W(2)) dut_b (
        .clk(clk), .CLB(rst), .bus(bus_b), .stat_clr(clr_b),
        .stat_fetch(sf_b), .stat_load(sl_b), .stat_conflict(sc_b)
    );

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] rpa;
    logic [3:0][7:0] rpb;
    bit mem_done;

    // read data is 0 except in the one cycle it is due, so a wrong capture cycle shows
    always @(posedge clk) begin
        if (!mem_done) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 8'(i) ^ 8'hA6;
                mem_b[i] <= 8'(i) ^ 8'hA6;
            end
            rpa <= '0;
            rpb <= '0;
            mem_done <= 1'b1;
        end else begin
            rpa <= (bus_a.m_en && !bus_a.m_we) ? mem_a[bus_a.m_addr] : 8'h00;
            rpb <= {rpb[2:0], (bus_b.m_en && !bus_b.m_we) ? mem_b[bus_b.m_addr] : 8'h00};
            if (bus_a.m_en && bus_a.m_we) mem_a[bus_a.m_addr] <= bus_a.m_wdata;
            if (bus_b.m_en && bus_b.m_we) mem_b[bus_b.m_addr] <= bus_b.m_wdata;
        end
    end

    assign bus_a.m_rdata = rpa;
    assign bus_b.m_rdata = rpb[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #2;
    endtask

    // one complete transaction on bus a (b=0) or b (b=1); optional stat_clr in the ack cycle
    task automatic run(input bit b, input bit ld, input bit we, input logic [7:0] addr,
                       input logic [7:0] wd, input bit clr, output logic [7:0] rd);
        bit ack = 1'b0;
        cyc();
        if (!b) begin
            if (ld) begin bus_a.l_req = 1; bus_a.l_we = we; bus_a.l_addr = addr; bus_a.l_wdata = wd; end
            else    begin bus_a.f_req = 1; bus_a.f_addr = addr; end
        end else begin
            if (ld) begin bus_b.l_req = 1; bus_b.l_we = we; bus_b.l_addr = addr; bus_b.l_wdata = wd; end
            else    begin bus_b.f_req = 1; bus_b.f_addr = addr; end
        end
        for (int k = 0; k < 16 && !ack; k++) begin
            smp();
            ack = b ? (ld ? bus_b.l_ack : bus_b.f_ack) : (ld ? bus_a.l_ack : bus_a.f_ack);
            if (!ack) cyc();
        end
        chk("ack_seen", {31'd0, ack}, 32'd1);
        rd = b ? (ld ? bus_b.l_rdata : bus_b.f_rdata) : (ld ? bus_a.l_rdata : bus_a.f_rdata);
        if (clr) begin
            if (b) clr_b = 1; else clr_a = 1;
        end
        cyc();
        if (b) begin bus_b.f_req = 0; bus_b.l_req = 0; bus_b.l_we = 0; end
        else   begin bus_a.f_req = 0; bus_a.l_req = 0; bus_a.l_we = 0; end
        clr_a = 0;
        clr_b = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        rst = 1; clr_a = 0; clr_b = 0;
        bus_a.f_req = 0; bus_a.f_addr = 0; bus_a.l_req = 0; bus_a.l_we = 0; bus_a.l_addr = 0; bus_a.l_wdata = 0;
        bus_b.f_req = 0; bus_b.f_addr = 0; bus_b.l_req = 0; bus_b.l_we = 0; bus_b.l_addr = 0; bus_b.l_wdata = 0;
        repeat (3) cyc();
        smp();
        chk("rst_a_ctl", {bus_a.f_gnt, bus_a.l_gnt, bus_a.f_ack, bus_a.l_ack, bus_a.m_en, bus_a.m_we, bus_a.m_addr}, 0);
        chk("rst_a_rd", {bus_a.f_rdata, bus_a.l_rdata}, 0);
        chk("rst_b_ctl", {bus_b.f_gnt, bus_b.l_gnt, bus_b.f_ack, bus_b.l_ack, bus_b.m_en, bus_b.m_wdata}, 0);
        chk("rst_stats", {sf_a, sl_a, sc_a}, 0);

        // fetch of 0x05 on the MEM_LAT=1 instance
        cyc(); rst = 0; bus_a.f_req = 1; bus_a.f_addr = 8'h05;
        smp(); chk("f_t0", {bus_a.cpu_stall, bus_a.m_en, bus_a.f_gnt}, 3'b100);
        cyc(); smp(); chk("f_acc", {bus_a.m_en, bus_a.m_we, bus_a.f_gnt, bus_a.l_gnt, bus_a.m_addr}, {4'b1010, 8'h05});
        cyc(); smp(); chk("f_wait", {bus_a.m_en, bus_a.m_addr, bus_a.f_ack, bus_a.cpu_stall, bus_a.f_gnt}, {1'b0, 8'h00, 3'b011});
        cyc(); smp(); chk("f_done", {bus_a.f_ack, bus_a.f_gnt, bus_a.cpu_stall}, 3'b110);
        chk("f_rdata", bus_a.f_rdata, 8'hA3);
        cyc(); bus_a.f_req = 0;
        smp(); chk("f_idle", {bus_a.f_ack, bus_a.f_gnt, bus_a.cpu_stall, bus_a.f_rdata}, {3'b000, 8'hA3});

        // loader write 0x3C to 0x10
        cyc(); bus_a.l_req = 1; bus_a.l_we = 1; bus_a.l_addr = 8'h10; bus_a.l_wdata = 8'h3C;
        cyc(); smp();
        chk("lw_acc", {bus_a.m_en, bus_a.m_we, bus_a.l_gnt, bus_a.f_gnt, bus_a.m_addr, bus_a.m_wdata}, {4'b1110, 8'h10, 8'h3C});
        cyc(); smp(); chk("lw_wait", {bus_a.l_ack, bus_a.m_en, bus_a.m_we, bus_a.m_wdata}, 0);
        cyc(); smp(); chk("lw_ack", {bus_a.l_ack, bus_a.l_gnt, bus_a.l_rdata}, {2'b11, 8'h00});
        cyc(); bus_a.l_req = 0; bus_a.l_we = 0;
        run(0, 1, 0, 8'h10, 8'h00, 0, rd);
        chk("lr_back", rd, 8'h3C);

        // three back-to-back conflicts from reset: fetch, loader, fetch
        cyc(); rst = 1;
        cyc(); rst = 0;
        bus_a.f_req = 1; bus_a.f_addr = 8'h21; bus_a.l_req = 1; bus_a.l_we = 0; bus_a.l_addr = 8'h30;
        cyc(); smp(); chk("cf1_gnt", {bus_a.f_gnt, bus_a.l_gnt}, 2'b10);
        cyc(); cyc(); smp(); chk("cf1_ack", {bus_a.f_ack, bus_a.f_rdata}, {1'b1, 8'h87});
        cyc(); bus_a.f_addr = 8'h22;
        cyc(); smp(); chk("cf2_gnt", {bus_a.f_gnt, bus_a.l_gnt, bus_a.m_we, bus_a.m_addr}, {3'b010, 8'h30});
        cyc(); cyc(); smp(); chk("cf2_ack", {bus_a.l_ack, bus_a.l_rdata}, {1'b1, 8'h96});
        cyc();
        cyc(); smp(); chk("cf3_gnt", {bus_a.f_gnt, bus_a.l_gnt, bus_a.m_addr}, {2'b10, 8'h22});
        cyc(); cyc(); smp(); chk("cf3_ack", {bus_a.f_ack, bus_a.f_rdata}, {1'b1, 8'h84});
        cyc(); bus_a.f_req = 0; bus_a.l_req = 0;
        smp(); chk("cf_stat", sc_a, STATS ? 16'd3 : 16'd0);

        // reset in WAIT aborts the fetch and restores fetch priority
        cyc(); bus_a.f_req = 1; bus_a.f_addr = 8'h05;
        cyc(); cyc(); rst = 1; bus_a.f_req = 0;
        cyc(); smp(); chk("rw_out", {bus_a.f_ack, bus_a.f_gnt, bus_a.l_gnt, bus_a.m_en, bus_a.cpu_stall}, 0);
        chk("rw_rd", bus_a.f_rdata, 8'h00);
        cyc(); rst = 0;
        bus_a.f_req = 1; bus_a.f_addr = 8'h05; bus_a.l_req = 1; bus_a.l_addr = 8'h30;
        cyc(); smp(); chk("rw_cf_gnt", {bus_a.f_gnt, bus_a.l_gnt}, 2'b10);
        cyc(); cyc(); smp(); chk("rw_ack", {bus_a.f_ack, bus_a.f_rdata}, {1'b1, 8'hA3});
        cyc(); bus_a.f_req = 0; bus_a.l_req = 0;
        cyc(); smp(); chk("rw_drop", {bus_a.l_gnt, bus_a.m_en}, 0);

        // statistics: five fetches, one load, then clear on the sixth fetch ack
        cyc(); rst = 1;
        cyc(); rst = 0;
        for (int i = 0; i < 5; i++) run(0, 0, 0, 8'(i), 8'h00, 0, rd);
        chk("st_last_rd", rd, 8'h04 ^ 8'hA6);
        run(0, 1, 0, 8'h10, 8'h00, 0, rd);
        smp(); chk("st_fetch5", sf_a, STATS ? 16'd5 : 16'd0);
        chk("st_load1", sl_a, STATS ? 16'd1 : 16'd0);
        run(0, 0, 0, 8'h07, 8'h00, 1, rd);
        smp(); chk("st_clr", {sf_a, sl_a, sc_a}, 0);

        // MEM_LAT=4 instance: fetch at t, loader raised at t+2
        cyc(); bus_b.f_req = 1; bus_b.f_addr = 8'h40;
        cyc(); smp(); chk("b_acc", {bus_b.m_en, bus_b.f_gnt, bus_b.m_addr}, {2'b11, 8'h40});
        cyc(); bus_b.l_req = 1; bus_b.l_we = 1; bus_b.l_addr = 8'h41; bus_b.l_wdata = 8'h77;
        smp(); chk("b_wait", {bus_b.m_en, bus_b.l_gnt, bus_b.f_gnt}, 3'b001);
        cyc(); cyc(); cyc(); smp(); chk("b_t5", {bus_b.f_ack, bus_b.cpu_stall}, 2'b01);
        cyc(); smp(); chk("b_t6", {bus_b.f_ack, bus_b.cpu_stall, bus_b.f_rdata}, {2'b10, 8'hE6});
        cyc(); bus_b.f_req = 0;
        smp(); chk("b_t7", {bus_b.m_en, bus_b.l_gnt, bus_b.f_gnt}, 0);
        cyc(); smp();
        chk("b_t8", {bus_b.m_en, bus_b.m_we, bus_b.l_gnt, bus_b.m_addr, bus_b.m_wdata}, {3'b111, 8'h41, 8'h77});
        repeat (4) cyc();
        smp(); chk("b_t12", bus_b.l_ack, 1'b0);
        cyc(); smp(); chk("b_t13", {bus_b.l_ack, bus_b.l_rdata}, {1'b1, 8'h00});
        cyc(); bus_b.l_req = 0; bus_b.l_we = 0;
        run(1, 1, 0, 8'h41, 8'h00, 0, rd);
        chk("b_rd41", rd, 8'h77);
        run(1, 1, 0, 8'h40, 8'h00, 0, rd);
        chk("b_rd40", rd, 8'hE6);
        run(1, 1, 0, 8'h42, 8'h00, 0, rd);
        chk("b_rd42", rd, 8'hE4);
        smp(); chk("b_st_load_sat", sl_b, STATS ? 2'd3 : 2'd0);
        chk("b_st_fetch", sf_b, STATS ? 2'd1 : 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
